// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// default geometry and the byte-address to word-index decode.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_LATENCY     = 2;
    localparam int unsigned DMEM_DEPTH_WORDS = 4096;
    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h8000_0000;

    typedef struct packed {
        logic        oor;
        logic [31:0] idx;
    } dmem_idx_t;

    // Underflow below the base wraps to a huge index and is caught by the range test.
    function automatic dmem_idx_t dmem_idx(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        dmem_idx_t   r;
        logic [31:0] off;
        off   = addr - base;
        r.idx = off >> 2;
        r.oor = (r.idx >= depth);
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and a registered read port.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [3:0]        wmask_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // The read register only moves on a read, so it holds its word while the response is up.
    always_ff @(posedge clock_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder: captures one request, waits LATENCY cycles,
// performs the access on the local SRAM and holds the response until accepted.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY     = DMEM_LATENCY,
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d_en,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    input  logic        d_accept,
    output logic        d_rready,
    output logic        d_wready,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    localparam int unsigned      CNT_W   = $clog2(LATENCY + 1);
    localparam int unsigned      ADDR_W  = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(LATENCY - 1);

    if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    dmem_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic             wen_q;
    logic             rready_q;
    logic             wready_q;
    logic             err_q;
    logic             rvld_q;

    logic             req;
    logic             idle;
    logic             exec;
    logic             acc_wen;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wmask;
    dmem_idx_t        acc;
    logic [31:0]      sram_rdata;
    logic             unused_idx_hi;

    assign req  = d_en | d_wen;
    assign idle = (state_q == IDLE);

    // With LATENCY==1 the access fires on the capture edge, so it must use the live request.
    assign acc_addr  = idle ? d_addr  : addr_q;
    assign acc_wdata = idle ? d_wdata : wdata_q;
    assign acc_wmask = idle ? d_wmask : wmask_q;
    assign acc_wen   = idle ? d_wen   : wen_q;
    assign acc       = dmem_idx(acc_addr, BASE_ADDR, DEPTH_WORDS);

    assign exec = (idle && req && (LATENCY == 1))
               || ((state_q == WAIT) && (cnt_q == CNT_ONE));

    assign unused_idx_hi = ^acc.idx[31:ADDR_W];

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .clock_i (clock),
        .en_i    (exec && !acc.oor),
        .we_i    (acc_wen),
        .wmask_i (acc_wmask),
        .idx_i   (acc.idx[ADDR_W-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            wen_q    <= 1'b0;
            rready_q <= 1'b0;
            wready_q <= 1'b0;
            err_q    <= 1'b0;
            rvld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        wmask_q <= d_wmask;
                        wen_q   <= d_wen;
                        cnt_q   <= CNT_RLD;
                        state_q <= WAIT;
                    end
                end
                WAIT: cnt_q <= cnt_q - CNT_ONE;
                DONE: begin
                    if (d_accept) begin
                        state_q  <= IDLE;
                        rready_q <= 1'b0;
                        wready_q <= 1'b0;
                        err_q    <= 1'b0;
                        rvld_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Execution overrides the state step above, covering both the IDLE and WAIT cases.
            if (exec) begin
                state_q  <= DONE;
                wready_q <= acc_wen;
                rready_q <= !acc_wen;
                err_q    <= acc.oor;
                rvld_q   <= !acc_wen && !acc.oor;
            end
        end
    end

    assign d_rready = rready_q;
    assign d_wready = wready_q;
    assign d_err    = err_q;
    assign d_rdata  = rvld_q ? sram_rdata : 32'd0;

endmodule
